// File: rtl/pol_map_fetch.sv
// pol_map_fetch
//   Neighbour-map fetcher for the pooling stage. Reads packed index words from
//   the global buffer, unpacks them into a stream of K indices per point, and
//   flags the last index of each point for the pooling core's idx handshake.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   Rst                             synchronous abort back to IDLE
//   CfgVld/CfgRdy, CfgK/CfgNp/CfgBaseAddr   job configuration
//   RdAddrVld/RdAddr/RdAddrRdy      global-buffer read requests
//   RdDatVld/RdDat/RdDatRdy         read data, returned in request order
//   IdxVld/Idx/IdxLast/IdxRdy       unpacked index stream
//   Busy                            job in progress
//   Done                            one-cycle pulse at job end
module pol_map_fetch #(
    parameter int IDX_WIDTH            = 10,
    parameter int POOL_MAP_DEPTH_WIDTH = 5,
    parameter int SRAM_WIDTH           = 256,
    parameter int ADDR_WIDTH           = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            Rst,
    input  logic                            CfgVld,
    output logic                            CfgRdy,
    input  logic [POOL_MAP_DEPTH_WIDTH-1:0] CfgK,
    input  logic [IDX_WIDTH-1:0]            CfgNp,
    input  logic [ADDR_WIDTH-1:0]           CfgBaseAddr,
    output logic                            RdAddrVld,
    output logic [ADDR_WIDTH-1:0]           RdAddr,
    input  logic                            RdAddrRdy,
    input  logic                            RdDatVld,
    input  logic [SRAM_WIDTH-1:0]           RdDat,
    output logic                            RdDatRdy,
    output logic                            IdxVld,
    output logic [IDX_WIDTH-1:0]            Idx,
    output logic                            IdxLast,
    input  logic                            IdxRdy,
    output logic                            Busy,
    output logic                            Done
);

    localparam int IPW    = SRAM_WIDTH / IDX_WIDTH;
    localparam int DATA_W = IPW * IDX_WIDTH;
    localparam int TOT_W  = IDX_WIDTH + POOL_MAP_DEPTH_WIDTH;
    localparam int SLOT_W = (IPW > 1) ? $clog2(IPW) : 1;
    localparam int KW     = POOL_MAP_DEPTH_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q,   state_d;
    logic [KW-1:0]         k_q,       k_d;
    logic [IDX_WIDTH-1:0]  np_q,      np_d;
    logic [ADDR_WIDTH-1:0] base_q,    base_d;
    logic [TOT_W-1:0]      req_cnt_q, req_cnt_d;
    logic [TOT_W-1:0]      emit_q,    emit_d;
    logic [1:0]            outst_q,   outst_d;
    logic                  buf_vld_q, buf_vld_d;
    logic [DATA_W-1:0]     buf_q,     buf_d;
    logic [SLOT_W-1:0]     slot_q,    slot_d;
    logic [KW-1:0]         pt_q,      pt_d;

    logic [TOT_W-1:0] total;
    logic [TOT_W-1:0] words;
    logic             req_fire, pop, last_idx, free_buf, load;
    logic [IDX_WIDTH-1:0] slots [IPW];

    // Bits above the last whole slot carry no index.
    logic unused_rd_dat;
    assign unused_rd_dat = ^RdDat[SRAM_WIDTH-1:DATA_W];

    for (genvar s = 0; s < IPW; s++) begin : g_slot
        assign slots[s] = buf_q[s*IDX_WIDTH +: IDX_WIDTH];
    end

    // Full-width product: Np*K never truncates.
    assign total = TOT_W'(np_q) * TOT_W'(k_q);
    assign words = TOT_W'((int'(total) + IPW - 1) / IPW);

    assign CfgRdy    = (state_q == ST_IDLE);
    assign Busy      = (state_q == ST_RUN);
    assign Done      = (state_q == ST_DONE);
    assign RdAddr    = base_q + ADDR_WIDTH'(req_cnt_q);
    // At most two words between request and final slot: one buffered, one in flight.
    assign RdAddrVld = Busy && (req_cnt_q < words) && ((outst_q + 2'(buf_vld_q)) < 2'd2);
    assign req_fire  = RdAddrVld && RdAddrRdy;

    assign IdxVld    = buf_vld_q;
    assign Idx       = slots[slot_q];
    assign IdxLast   = buf_vld_q && (pt_q == k_q - KW'(1));
    assign pop       = buf_vld_q && IdxRdy;
    assign last_idx  = (emit_q == total - TOT_W'(1));
    assign free_buf  = pop && ((slot_q == SLOT_W'(IPW - 1)) || last_idx);
    // Accepting a word while its predecessor drains its final slot avoids a bubble.
    assign RdDatRdy  = !buf_vld_q || free_buf;
    // Unrequested data (e.g. stale after an abort) is accepted and dropped.
    assign load      = RdDatVld && RdDatRdy && Busy && (outst_q != 2'd0);

    // NOTE: every next-state signal gets its default first, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        np_d      = np_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        emit_d    = emit_q;
        outst_d   = outst_q;
        buf_vld_d = buf_vld_q;
        buf_d     = buf_q;
        slot_d    = slot_q;
        pt_d      = pt_q;

        case (state_q)
            ST_IDLE: begin
                if (CfgVld) begin
                    k_d       = CfgK;
                    np_d      = CfgNp;
                    base_d    = CfgBaseAddr;
                    req_cnt_d = '0;
                    emit_d    = '0;
                    outst_d   = '0;
                    buf_vld_d = 1'b0;
                    slot_d    = '0;
                    pt_d      = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req_fire) req_cnt_d = req_cnt_q + TOT_W'(1);
                outst_d = outst_q + 2'(req_fire) - 2'(load);

                if (load) begin
                    buf_d     = RdDat[DATA_W-1:0];
                    buf_vld_d = 1'b1;
                end else if (free_buf) begin
                    buf_vld_d = 1'b0;
                end

                if (load || free_buf) slot_d = '0;
                else if (pop)         slot_d = slot_q + SLOT_W'(1);

                if (pop) begin
                    emit_d = emit_q + TOT_W'(1);
                    pt_d   = (pt_q == k_q - KW'(1)) ? '0 : pt_q + KW'(1);
                end

                if ((total == '0) || (pop && last_idx)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything decided above.
        if (Rst) begin
            state_d   = ST_IDLE;
            k_d       = '0;
            np_d      = '0;
            base_d    = '0;
            req_cnt_d = '0;
            emit_d    = '0;
            outst_d   = '0;
            buf_vld_d = 1'b0;
            buf_d     = '0;
            slot_d    = '0;
            pt_d      = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the word buffer is a single register, not a RAM, so it is reset;
    // that keeps Idx at zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            np_q      <= '0;
            base_q    <= '0;
            req_cnt_q <= '0;
            emit_q    <= '0;
            outst_q   <= '0;
            buf_vld_q <= 1'b0;
            buf_q     <= '0;
            slot_q    <= '0;
            pt_q      <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            np_q      <= np_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            emit_q    <= emit_d;
            outst_q   <= outst_d;
            buf_vld_q <= buf_vld_d;
            buf_q     <= buf_d;
            slot_q    <= slot_d;
            pt_q      <= pt_d;
        end
    end

endmodule
